// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: opcodes, FSM encoding,
// MEM/WB payload and load/store decode helpers.
package mem_stage_pkg;

   localparam int unsigned OPC_W = 6;
   localparam int unsigned WORD_W = 32;

   localparam logic [OPC_W-1:0] OP_LB  = 6'h20;
   localparam logic [OPC_W-1:0] OP_LH  = 6'h21;
   localparam logic [OPC_W-1:0] OP_LW  = 6'h23;
   localparam logic [OPC_W-1:0] OP_LBU = 6'h24;
   localparam logic [OPC_W-1:0] OP_LHU = 6'h25;
   localparam logic [OPC_W-1:0] OP_SB  = 6'h28;
   localparam logic [OPC_W-1:0] OP_SH  = 6'h29;
   localparam logic [OPC_W-1:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [WORD_W-1:0] ins;
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] alu;
      logic [WORD_W-1:0] mem_data;
      logic              align_err;
   } memwb_t;

   function automatic logic is_load(input logic [OPC_W-1:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [OPC_W-1:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input logic [OPC_W-1:0] op, input logic [1:0] a);
      return ((op == OP_LW) && (a != 2'b00)) ||
             (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && a[0]);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed byte/halfword from the memory
// word and sign- or zero-extends it to 32 bits.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [WORD_W-1:0] rdata_i,
   input  logic [OPC_W-1:0]  op_i,
   input  logic [1:0]        a_i,
   output logic [WORD_W-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (a_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (op_i)
         OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data_o = {24'd0, byte_sel};
         OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data_o = {16'd0, half_sel};
         OP_LW:   data_o = rdata_i;
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: split-transaction data-memory access FSM, upstream stall
// and MEM/WB register. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       ins_m,
   input  logic [31:0]       pc_m,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] rt_data,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [31:0]       ins_w,
   output logic [31:0]       pc_w,
   output logic [DATA_W-1:0] alu_result_w,
   output logic [DATA_W-1:0] mem_data_w,
   output logic              align_err
);

   state_e              state_q, state_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [3:0]          be_q, be_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   ld_q, ld_d;
   logic                err_q, err_d;
   memwb_t              wb_q, wb_d;

   logic [OPC_W-1:0]    op;
   logic [1:0]          a;
   logic                mem_op;
   logic                misal;
   logic [3:0]          lane_be;
   logic [DATA_W-1:0]   lane_wdata;
   logic [DATA_W-1:0]   ld_aligned;

   assign op     = ins_m[31:26];
   assign a      = alu_result[1:0];
   assign mem_op = is_load(op) || is_store(op);

`ifdef MEM_ALIGN_CHECK_EN
   assign misal = is_misaligned(op, a);
`else
   assign misal = 1'b0;
`endif

   mem_load_align u_align (
      .rdata_i (dmem_rdata),
      .op_i    (op),
      .a_i     (a),
      .data_o  (ld_aligned)
   );

   // Byte lanes and replicated store data by access size
   always_comb begin
      case (op)
         OP_LB, OP_LBU, OP_SB: begin
            lane_be    = 4'b0001 << a;
            lane_wdata = {4{rt_data[7:0]}};
         end
         OP_LH, OP_LHU, OP_SH: begin
            lane_be    = a[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{rt_data[15:0]}};
         end
         default: begin
            lane_be    = 4'b1111;
            lane_wdata = rt_data;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      ld_d    = ld_q;
      err_d   = err_q;
      stall   = 1'b0;
      wb_d    = '0;

      case (state_q)
         IDLE: begin
            if (mem_op) begin
               stall = 1'b1;
               ld_d  = '0;
               err_d = misal;
               if (misal) begin
                  state_d = DONE;
               end else begin
                  req_d   = 1'b1;
                  we_d    = is_store(op);
                  addr_d  = ADDR_W'({alu_result[31:2], 2'b00});
                  be_d    = lane_be;
                  wdata_d = is_store(op) ? lane_wdata : '0;
                  state_d = ISSUE;
               end
            end else begin
               wb_d.ins = ins_m;
               wb_d.pc  = pc_m;
               wb_d.alu = alu_result;
            end
         end
         ISSUE: begin
            stall = 1'b1;
            if (dmem_ready) begin
               req_d   = 1'b0;
               state_d = we_q ? DONE : RESP;
            end
         end
         RESP: begin
            stall = 1'b1;
            if (dmem_rvalid) begin
               ld_d    = ld_aligned;
               state_d = DONE;
            end
         end
         DONE: begin
            wb_d.ins       = ins_m;
            wb_d.pc        = pc_m;
            wb_d.alu       = alu_result;
            wb_d.mem_data  = ld_q;
            wb_d.align_err = err_q;
            err_d          = 1'b0;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         ld_q    <= '0;
         err_q   <= 1'b0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         ld_q    <= ld_d;
         err_q   <= err_d;
         wb_q    <= wb_d;
      end
   end

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_be      = be_q;
   assign dmem_wdata   = wdata_q;
   assign ins_w        = wb_q.ins;
   assign pc_w         = wb_q.pc;
   assign alu_result_w = wb_q.alu;
   assign mem_data_w   = wb_q.mem_data;
   assign align_err    = wb_q.align_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (both MEM_ALIGN_CHECK_EN builds).
module tb_mem_access_stage;

   localparam logic [31:0] I_ADD = 32'h0085_1820;
   localparam logic [31:0] I_LB  = 32'h8008_0000;
   localparam logic [31:0] I_LH  = 32'h8408_0000;
   localparam logic [31:0] I_LW  = 32'h8C08_0000;
   localparam logic [31:0] I_LBU = 32'h9008_0000;
   localparam logic [31:0] I_LHU = 32'h9408_0000;
   localparam logic [31:0] I_SB  = 32'hA008_0000;
   localparam logic [31:0] I_SH  = 32'hA408_0000;
   localparam logic [31:0] I_SW  = 32'hAC08_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ins_m, pc_m, alu_result, rt_data;
   logic        stall;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [31:0] ins_w, pc_w, alu_result_w, mem_data_w;
   logic        align_err;

   int n_tests = 0;
   int n_fail  = 0;
   int stall_cnt, req_cnt;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;

   mem_access_stage dut (
      .clk          (clk),
      .reset        (reset),
      .ins_m        (ins_m),
      .pc_m         (pc_m),
      .alu_result   (alu_result),
      .rt_data      (rt_data),
      .stall        (stall),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_ready   (dmem_ready),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .ins_w        (ins_w),
      .pc_w         (pc_w),
      .alu_result_w (alu_result_w),
      .mem_data_w   (mem_data_w),
      .align_err    (align_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one memory op through accept (and response for loads), then retire it
   task automatic run_op(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [31:0] rdata, input int unsigned rwait,
                         input logic load, input logic early_rv);
      ins_m = ins; pc_m = alu + 32'h1000; alu_result = alu; rt_data = rt;
      #1;
      chk("stall_idle", 32'(stall), 32'h1);
      step();
      chk("req_issue", 32'(dmem_req), 32'h1);
      cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata; cap_we = dmem_we;
      dmem_ready = 1'b1;
      if (early_rv) begin
         dmem_rvalid = 1'b1;
         dmem_rdata  = 32'h5A5A_5A5A;
      end
      step();
      dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      if (load) begin
         repeat (rwait) step();
         dmem_rvalid = 1'b1; dmem_rdata = rdata;
         step();
         dmem_rvalid = 1'b0;
      end
      chk("stall_done", 32'(stall), 32'h0);
      chk("req_done", 32'(dmem_req), 32'h0);
      step();
      ins_m = 32'h0;
      chk("ins_w_retire", ins_w, ins);
      chk("pc_w_retire", pc_w, alu + 32'h1000);
   endtask

   initial begin
      reset = 1'b0; ins_m = '0; pc_m = '0; alu_result = '0; rt_data = '0;
      dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (2) step();
      chk("rst_req", 32'(dmem_req), 32'h0);
      chk("rst_ins_w", ins_w, 32'h0);
      chk("rst_be", 32'(dmem_be), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      reset = 1'b1;
      step();

      // Non-memory op: single-cycle pass-through
      ins_m = I_ADD; pc_m = 32'h10; alu_result = 32'h1234;
      #1;
      chk("add_stall", 32'(stall), 32'h0);
      step();
      ins_m = 32'h0;
      chk("add_ins_w", ins_w, I_ADD);
      chk("add_alu_w", alu_result_w, 32'h1234);
      chk("add_pc_w", pc_w, 32'h10);
      chk("add_mem_w", mem_data_w, 32'h0);
      chk("add_req", 32'(dmem_req), 32'h0);

      // SW with three stalled ISSUE cycles
      ins_m = I_SW; pc_m = 32'h20; alu_result = 32'h100; rt_data = 32'hDEAD_BEEF;
      #1;
      stall_cnt = 0; req_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) dmem_ready = 1'b1;
         stall_cnt += int'(stall);
         req_cnt   += int'(dmem_req);
         if (i == 1) begin
            chk("sw_addr", dmem_addr, 32'h100);
            chk("sw_be", 32'(dmem_be), 32'hF);
            chk("sw_we", 32'(dmem_we), 32'h1);
            chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
            chk("sw_bubble", ins_w, 32'h0);
         end
         if (i == 4) chk("sw_addr_stable", dmem_addr, 32'h100);
         if (i == 5) chk("sw_done_stall", 32'(stall), 32'h0);
         step();
         dmem_ready = 1'b0;
      end
      ins_m = 32'h0;
      chk("sw_stall_cycles", 32'(stall_cnt), 32'd5);
      chk("sw_req_cycles", 32'(req_cnt), 32'd4);
      chk("sw_ins_w", ins_w, I_SW);
      chk("sw_alu_w", alu_result_w, 32'h100);
      chk("sw_mem_w", mem_data_w, 32'h0);
      step();
      chk("sw_no_dup_req", 32'(dmem_req), 32'h0);
      chk("sw_wb_once", ins_w, 32'h0);

      // LB with rvalid during accept (ignored) and real rvalid two cycles later
      run_op(I_LB, 32'h103, 32'h0, 32'h80FF_0000, 1, 1'b1, 1'b1);
      chk("lb_addr", cap_addr, 32'h100);
      chk("lb_we", 32'(cap_we), 32'h0);
      chk("lb_data", mem_data_w, 32'hFFFF_FF80);
      run_op(I_LBU, 32'h103, 32'h0, 32'h80FF_0000, 1, 1'b1, 1'b0);
      chk("lbu_data", mem_data_w, 32'h0000_0080);

      // Halfword store and loads
      run_op(I_SH, 32'h102, 32'h0000_ABCD, 32'h0, 0, 1'b0, 1'b0);
      chk("sh_be", 32'(cap_be), 32'hC);
      chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      chk("sh_addr", cap_addr, 32'h100);
      chk("sh_mem_w", mem_data_w, 32'h0);
      run_op(I_LHU, 32'h102, 32'h0, 32'hABCD_1234, 0, 1'b1, 1'b0);
      chk("lhu_data", mem_data_w, 32'h0000_ABCD);
      run_op(I_LH, 32'h100, 32'h0, 32'h1234_8001, 2, 1'b1, 1'b0);
      chk("lh_data", mem_data_w, 32'hFFFF_8001);
      run_op(I_SB, 32'h101, 32'h0000_00A5, 32'h0, 0, 1'b0, 1'b0);
      chk("sb_be", 32'(cap_be), 32'h2);
      chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);

      // Asynchronous reset: MEM/WB, request, and mid-RESP abandon
      ins_m = I_ADD; pc_m = 32'h80; alu_result = 32'h55;
      step();
      chk("pre_rst_wb", ins_w, I_ADD);
      ins_m = I_LW; alu_result = 32'h200;
      #2 reset = 1'b0;
      #1;
      chk("async_wb_ins", ins_w, 32'h0);
      chk("async_wb_alu", alu_result_w, 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      step();
      chk("req_before_rst", 32'(dmem_req), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("async_req_clear", 32'(dmem_req), 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      step();
      dmem_ready = 1'b1;
      step();
      dmem_ready = 1'b0;
      chk("stall_resp", 32'(stall), 32'h1);
      #2 reset = 1'b0;
      #1;
      ins_m = 32'h0;
      #1;
      chk("rst_resp_req", 32'(dmem_req), 32'h0);
      chk("rst_resp_wb", ins_w, 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      step();
      dmem_rvalid = 1'b0;
      chk("stale_rv_stall", 32'(stall), 32'h0);
      chk("stale_rv_mem", mem_data_w, 32'h0);
      chk("stale_rv_ins", ins_w, 32'h0);
      step();
      chk("stale_rv_mem2", mem_data_w, 32'h0);

      // Misaligned word load
`ifdef MEM_ALIGN_CHECK_EN
      ins_m = I_LW; pc_m = 32'h300; alu_result = 32'h101;
      #1;
      chk("mis_stall_idle", 32'(stall), 32'h1);
      step();
      chk("mis_no_req", 32'(dmem_req), 32'h0);
      chk("mis_done_stall", 32'(stall), 32'h0);
      step();
      ins_m = 32'h0;
      chk("mis_align_err", 32'(align_err), 32'h1);
      chk("mis_ins_w", ins_w, I_LW);
      chk("mis_mem_w", mem_data_w, 32'h0);
      step();
      chk("mis_err_once", 32'(align_err), 32'h0);
      chk("mis_req_after", 32'(dmem_req), 32'h0);
`else
      run_op(I_LW, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 1'b1, 1'b0);
      chk("mis_addr", cap_addr, 32'h100);
      chk("mis_be", 32'(cap_be), 32'hF);
      chk("mis_data", mem_data_w, 32'hCAFE_F00D);
      chk("mis_align_err", 32'(align_err), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs (ins_m, pc_m, alu_result, rt_data).
- Performs load/store access to an external data memory over a req/ready/rvalid split-transaction interface, and stalls the front of the pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register feeding write-back.

Parameters:
- ADDR_W, 32, data-memory byte-address width (dmem_addr width).
- DATA_W, 32, datapath width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ins_m  input  32  instruction in MEM stage (0 = bubble).
- pc_m  input  32  PC of that instruction.
- alu_result  input  32  effective address for load/store; result otherwise.
- rt_data  input  32  store data source.
- stall  output  1  combinational; high = upstream (PC, IF/ID, ID/EX, EX/MEM) must hold.
- dmem_req  output  1  registered request valid.
- dmem_we  output  1  registered; 1 = store.
- dmem_addr  output  ADDR_W  registered; word-aligned ({alu_result[31:2],2'b00}).
- dmem_be  output  4  registered byte enables, little-endian.
- dmem_wdata  output  32  registered store data, lane-replicated.
- dmem_ready  input  1  memory accepts request this cycle.
- dmem_rvalid  input  1  load data valid this cycle.
- dmem_rdata  input  32  load data word.
- ins_w  output  32  MEM/WB instruction.
- pc_w  output  32  MEM/WB PC.
- alu_result_w  output  32  MEM/WB ALU result.
- mem_data_w  output  32  MEM/WB aligned, extended load data (0 for non-loads).
- align_err  output  1  MEM/WB misalignment flag (see Optional Feature).

Behaviour:
- Decode opcode ins_m[31:26]:
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - Anything else is a non-memory op.
- Reset (reset==0, asynchronous): state IDLE; dmem_req/we/addr/be/wdata = 0; ins_w, pc_w, alu_result_w, mem_data_w, align_err = 0. An outstanding request is abandoned immediately; a late dmem_rvalid after reset is ignored.
- FSM states and transitions:
  - IDLE:
    - Non-memory op: stall=0; MEM/WB captures at the edge; 1-cycle latency.
    - Memory op: stall=1; register request fields; next state ISSUE.
  - ISSUE: dmem_req=1, stall=1. Request fields are stable until dmem_ready.
    - dmem_ready=1 with store: next DONE.
    - dmem_ready=1 with load: next RESP.
    - dmem_req drops at the edge after acceptance.
  - RESP: stall=1. When dmem_rvalid=1, latch aligned load data; next DONE. dmem_rvalid arriving the same cycle as dmem_ready is ignored; the response is taken from RESP only.
  - DONE: stall=0; MEM/WB captures the instruction plus latched data; next IDLE.
- Latency: store 3 cycles minimum, load 4 cycles minimum.
- While stall=1, MEM/WB loads a bubble (all fields 0) every edge, so WB never repeats a write.
- Store lanes (a = alu_result[1:0]):
  - SW: be=1111, wdata=rt.
  - SH: be = a[1] ? 1100 : 0011; wdata = {2{rt[15:0]}}.
  - SB: be = 0001<<a; wdata = {4{rt[7:0]}}.
- Load extract:
  - LB/LBU: byte a, sign-/zero-extended.
  - LH/LHU: half a[1], sign-/zero-extended.
  - LW: full word.
- dmem_rvalid or dmem_ready outside the states that expect it: ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - LW with a!=0, or LH/LHU/SH with a[0]!=0, issues no memory request.
  - IDLE goes directly to DONE (2-cycle latency).
  - MEM/WB captures ins_w=ins_m, mem_data_w=0, align_err=1 for that one cycle.
- Undefined:
  - Low address bits are ignored (halfword uses a[1] only; word is aligned down).
  - align_err is tied to 0.

Decomposition:
- Package mem_stage_pkg holds:
  - opcode localparams (OP_LB … OP_SW);
  - FSM state encoding (IDLE, ISSUE, RESP, DONE, 2 bits);
  - is_load/is_store decode functions.
- Sub-module mem_load_align: combinational extract/extend from (rdata, opcode, a) to a 32-bit result. The FSM and MEM/WB register stay in mem_access_stage.

Test Plan:
- Non-memory op ADD, alu_result=0x1234 -> stall stays 0; next edge ins_w=ADD, alu_result_w=0x1234, mem_data_w=0.
- SW addr 0x100, rt=0xDEADBEEF, dmem_ready held 0 for 3 ISSUE cycles then 1:
  - dmem_req held, addr 0x100, be=1111;
  - stall high 5 cycles; one DONE cycle; no duplicate request.
- LB addr 0x103, rdata=0x80FF_0000, rvalid 2 cycles after accept -> mem_data_w=0xFFFFFF80; LBU on the same data -> 0x00000080.
- SH addr 0x102, rt=0x0000ABCD -> be=1100, wdata=0xABCDABCD; LHU addr 0x102, rdata=0xABCD1234 -> 0x0000ABCD.
- reset driven low during RESP -> dmem_req=0 and MEM/WB all 0 immediately (asynchronous); after release, state is IDLE and the stale rvalid is ignored.
- MEM_ALIGN_CHECK_EN defined, LW addr 0x101 -> no dmem_req; align_err=1 for one cycle; mem_data_w=0. Undefined: access goes to 0x100 with be=1111.
